link_frame_rx: RTL
==================

Name: link_frame_rx

Overview:
- Byte-to-word deframer for the inter-board serial link.
- Sits between a UART byte receiver and the external-data mux. It consumes received bytes and checks sync and checksum.
- It presents each validated 32-bit payload (board ID in [31:24], 24-bit BCD points in [23:0]) to the mux and board-ID logic.
- It tracks link liveness and clears stale data when the peer goes silent, so a vanished board releases its ID slot.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
BYTE_GAP, 75000, max clk cycles between bytes inside a frame before abort (1 ms at 75 MHz)
LINK_TIMEOUT, 7500000, clk cycles without a good frame before link declared down (100 ms at 75 MHz)

Ports:
clk  in  1  pixel-domain clock (75 MHz)
rst  in  1  asynchronous active-high reset
rx_byte  in  8  received byte from UART receiver
rx_valid  in  1  one-cycle strobe, rx_byte valid
data_out  out  32  last validated payload, MSB byte first on the wire
data_valid  out  1  one-cycle pulse, data_out just updated
frame_err  out  1  one-cycle pulse on checksum failure or gap abort
link_up  out  1  high while good frames arrive within LINK_TIMEOUT
good_cnt  out  8  wrapping count of validated frames

Behaviour:
- Reset (async, rst=1): all outputs 0, state HUNT, all counters 0. Reset mid-frame discards the partial frame.
- Frame on the wire: SYNC_BYTE, P3, P2, P1, P0, CHK. CHK = P3^P2^P1^P0. There is no byte escaping.
- FSM states, advanced only on rx_valid except where noted:
  - HUNT: byte==SYNC_BYTE -> PAYLOAD, idx=0, chk=0. Other bytes are ignored silently, with no frame_err.
  - PAYLOAD: shift_reg <= {shift_reg[23:0], rx_byte}, chk <= chk^rx_byte, idx++. After the 4th byte (idx==3) -> CHECK. A byte equal to SYNC_BYTE here is payload data.
  - CHECK, rx_byte==chk: data_out <= shift_reg; data_valid=1 the next cycle; link_up=1; link counter cleared; good_cnt++ (wraps 255->0); -> HUNT.
  - CHECK, rx_byte!=chk: frame_err=1 the next cycle, data_out unchanged -> HUNT.
- Latency: data_valid and frame_err assert exactly 1 cycle after the rx_valid of the CHK byte.
- Gap timer:
  - Counts clk cycles in PAYLOAD/CHECK; cleared on every rx_valid and in HUNT.
  - Reaching BYTE_GAP-1 without rx_valid -> HUNT, frame_err pulse, partial data discarded.
  - If rx_valid coincides with the timeout cycle, the byte is processed and the timer clears (no abort).
- Link timer:
  - Free-running, saturates at LINK_TIMEOUT; cleared on each good frame.
  - On reaching LINK_TIMEOUT: link_up=0 and data_out=0. ID 0 means unoccupied. No data_valid pulse is issued.
  - A good frame completing on the same cycle wins: link_up stays 1 and data_out loads.
- Counter widths: gap counter is clog2(BYTE_GAP) bits, link counter is clog2(LINK_TIMEOUT+1) bits. Neither wraps.
- data_valid and frame_err are never high together.
- rx_valid held high for multiple cycles is treated as multiple bytes.

Test Plan:
Bench uses BYTE_GAP=50, LINK_TIMEOUT=1000, bytes spaced 10 cycles apart.
1. Good frame: send A5,02,00,12,34,24 -> data_out=32'h02001234, one data_valid pulse 1 cycle after the CHK strobe, link_up=1, good_cnt=1, frame_err=0.
2. Bad checksum: send A5,02,00,12,34,25 -> frame_err pulse, data_out holds its previous value, good_cnt unchanged. The next good frame is accepted.
3. Sync inside payload, plus leading garbage: send 00,FF,A5,A5,01,02,03,A5 (CHK=A5^01^02^03=A5) -> data_out=32'hA5010203, data_valid pulse. The garbage bytes produce no frame_err.
4. Gap abort: send A5,02,00 then idle 60 cycles -> frame_err at cycle 50 after the last byte. A following full good frame is accepted normally.
5. Link timeout: one good frame, then silence -> link_up falls and data_out=0 exactly 1000 cycles after the data_valid. A good frame completing on the timeout cycle keeps link_up=1.
6. Async reset mid-frame: assert rst after A5,02 -> all outputs 0 immediately. After release, a complete good frame decodes correctly. Also check 256 good frames wrap good_cnt to 0.

Source files
------------

// File: rtl/link_frame_rx.sv
// Byte-to-word deframer for the inter-board serial link.
// Takes bytes from the UART receiver. A frame is SYNC, P3, P2, P1, P0, CHK,
// with CHK = P3^P2^P1^P0. The block publishes each validated 32-bit payload.
// It watches for inter-byte gaps and for link silence. When the peer goes
// quiet, data_out is cleared to zero, so the peer's board-ID slot is released.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_HUNT    | waiting for SYNC_BYTE, other bytes dropped
// ST_PAYLOAD | collecting the four payload bytes, MSB first
// ST_CHECK   | waiting for the checksum byte
module link_frame_rx #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned BYTE_GAP     = 75000,
    parameter int unsigned LINK_TIMEOUT = 7500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        frame_err,
    output logic        link_up,
    output logic [7:0]  good_cnt
);

    localparam int GAP_W  = $clog2(BYTE_GAP);
    localparam int LINK_W = $clog2(LINK_TIMEOUT + 1);

    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(BYTE_GAP - 1);
    localparam logic [LINK_W-1:0] LINK_MAX  = LINK_W'(LINK_TIMEOUT);
    localparam logic [LINK_W-1:0] LINK_LAST = LINK_W'(LINK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic [1:0]         idx_q,        idx_d;
    logic [7:0]         chk_q,        chk_d;
    logic [31:0]        shift_q,      shift_d;
    logic [GAP_W-1:0]   gap_q,        gap_d;
    logic [LINK_W-1:0]  link_q,       link_d;
    logic [31:0]        data_out_q,   data_out_d;
    logic               data_valid_q, data_valid_d;
    logic               frame_err_q,  frame_err_d;
    logic               link_up_q,    link_up_d;
    logic [7:0]         good_cnt_q,   good_cnt_d;

    // Next-state logic. The link timer is evaluated first, so a good frame
    // completing in the same cycle as the timeout overrides the timeout.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        chk_d        = chk_q;
        shift_d      = shift_q;
        gap_d        = gap_q;
        link_d       = link_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        link_up_d    = link_up_q;
        good_cnt_d   = good_cnt_q;

        if (link_q == LINK_LAST) begin
            link_d     = LINK_MAX;
            link_up_d  = 1'b0;
            data_out_d = '0;
        end else if (link_q != LINK_MAX) begin
            link_d = link_q + 1'b1;
        end

        case (state_q)
            ST_HUNT: begin
                gap_d = '0;
                if (rx_valid && (rx_byte == SYNC_BYTE)) begin
                    state_d = ST_PAYLOAD;
                    idx_d   = 2'd0;
                    chk_d   = 8'h00;
                end
            end

            ST_PAYLOAD: begin
                if (rx_valid) begin
                    gap_d   = '0;
                    shift_d = {shift_q[23:0], rx_byte};
                    chk_d   = chk_q ^ rx_byte;
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = ST_CHECK;
                    end
                end else if (gap_q == GAP_LAST) begin
                    state_d     = ST_HUNT;
                    frame_err_d = 1'b1;
                    gap_d       = '0;
                    shift_d     = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            ST_CHECK: begin
                if (rx_valid) begin
                    gap_d   = '0;
                    state_d = ST_HUNT;
                    if (rx_byte == chk_q) begin
                        data_out_d   = shift_q;
                        data_valid_d = 1'b1;
                        link_up_d    = 1'b1;
                        link_d       = '0;
                        good_cnt_d   = good_cnt_q + 8'd1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (gap_q == GAP_LAST) begin
                    state_d     = ST_HUNT;
                    frame_err_d = 1'b1;
                    gap_d       = '0;
                    shift_d     = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_HUNT;
                gap_d   = '0;
            end
        endcase
    end

    // State, timers and registered outputs. Reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_HUNT;
            idx_q        <= 2'd0;
            chk_q        <= 8'h00;
            shift_q      <= '0;
            gap_q        <= '0;
            link_q       <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            link_up_q    <= 1'b0;
            good_cnt_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            chk_q        <= chk_d;
            shift_q      <= shift_d;
            gap_q        <= gap_d;
            link_q       <= link_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            link_up_q    <= link_up_d;
            good_cnt_q   <= good_cnt_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign link_up    = link_up_q;
    assign good_cnt   = good_cnt_q;

endmodule
